uart_fifo_bridge: RTL and testbench
===================================

Name: uart_fifo_bridge

Overview:
- Buffering stage between the CPU data bus and the UART data-register interface.
- TX FIFO: accepts CPU byte writes and drains them into the UART's write/wait handshake.
- RX FIFO: pulls received bytes from the UART's valid/data/read-strobe interface and presents them to the CPU first-word-fall-through.
- Purpose: the CPU stalls only when the TX FIFO is full, and back-to-back received bytes are not lost while the CPU is busy.

Parameters:
- TX_LOG2, default 4: TX FIFO depth is 2**TX_LOG2. Legal range 1..7.
- RX_LOG2, default 4: RX FIFO depth is 2**RX_LOG2. Legal range 1..7.

Ports:
- clk, input, 1: clock.
- resetn, input, 1: reset, synchronous, active-low; clock clk.
- cpu_dat_we, input, 1: CPU write strobe to the data register.
- cpu_dat_di, input, 32: CPU write data; only [7:0] is used.
- cpu_dat_wait, output, 1: stall; high when cpu_dat_we is high and the TX FIFO is full.
- cpu_dat_re, input, 1: CPU read strobe; pops the RX FIFO.
- cpu_dat_do, output, 32: RX head byte, or all-ones when empty.
- cpu_stat_do, output, 32: status word.
- cpu_stat_clr, input, 1: clears the sticky rx_stall flag.
- uart_dat_we, output, 1: write strobe to the UART.
- uart_dat_di, output, 8: TX head byte to the UART.
- uart_dat_wait, input, 1: UART busy; high means the write is not accepted this cycle.
- uart_dat_do, input, 9: from the UART; [8] = byte valid, [7:0] = data.
- uart_dat_re, output, 1: registered one-cycle read strobe to the UART.

Behaviour:
- Reset (resetn low at a clk edge):
  - Both FIFO pointers and counts go to 0; uart_dat_re = 0; rx_stall = 0.
  - Resulting outputs: uart_dat_we = 0, cpu_dat_do = 32'hFFFF_FFFF, cpu_dat_wait = 0.
  - FIFO contents are discarded. Reset mid-transfer simply drops queued bytes; no partial state survives.
- FIFO storage:
  - Circular buffers with read/write pointers of width LOG2 that wrap modulo depth.
  - Occupancy counters of width LOG2+1, ranging 0..depth.
  - full = (count == depth); empty = (count == 0).
- TX push:
  - On a clk edge with cpu_dat_we = 1 and TX not full, write cpu_dat_di[7:0] and increment the count.
  - cpu_dat_wait = cpu_dat_we & tx_full, combinational.
  - Full-state gating uses the current-cycle full flag. A write while full is blocked even if a drain pops in the same cycle; the CPU retries next cycle.
- TX drain:
  - uart_dat_we = !tx_empty, combinational; uart_dat_di = TX head.
  - A pop occurs at the edge where uart_dat_we = 1 and uart_dat_wait = 0.
  - Simultaneous push and pop: count unchanged, both pointers advance.
- RX pull:
  - At a clk edge with uart_dat_do[8] = 1, RX not full, and uart_dat_re currently 0: push uart_dat_do[7:0] and set uart_dat_re = 1 for exactly one cycle.
  - Otherwise uart_dat_re = 0.
  - The !uart_dat_re guard prevents double-capture during the cycle in which the UART is still clearing its valid bit.
  - If the UART re-asserts valid with a new byte on the same edge it sees the strobe, that byte is pulled at the next qualifying edge. Minimum spacing is 2 cycles per byte.
- RX stall: while the RX FIFO is full and uart_dat_do[8] = 1, the byte is left in the UART and the sticky rx_stall flag is set.
- CPU read:
  - cpu_dat_do is combinational: {24'h0, RX head} when not empty, 32'hFFFF_FFFF when empty.
  - cpu_dat_re pops at the edge when not empty. A pop when empty is ignored.
  - RX push and pop in the same cycle: count unchanged.
  - A push while full is blocked even if a pop occurs that cycle (current-cycle full flag).
- Status word cpu_stat_do, combinational from registers:
  - [7:0] = rx_count, zero-extended.
  - [15:8] = tx_count, zero-extended.
  - [16] = rx_empty; [17] = rx_full; [18] = tx_empty; [19] = tx_full.
  - [20] = rx_stall.
  - [31:21] = 0.
- rx_stall control: cpu_stat_clr clears rx_stall at the edge. A set condition in the same cycle wins over the clear.
- Latency:
  - CPU write to uart_dat_we high: 1 cycle (visible after the push edge).
  - UART valid to cpu_dat_do showing the byte: 1 cycle.

Test Plan:
1. Reset: hold resetn low 2 cycles, then release. Require uart_dat_we = 0, uart_dat_re = 0, cpu_dat_do = 32'hFFFF_FFFF, cpu_stat_do = 32'h0005_0000.
2. TX ordering with a busy UART: write 0x41, 0x42, 0x43 while the UART model holds uart_dat_wait = 1 for 10 cycles per byte. Require uart_dat_di to present 0x41, 0x42, 0x43 in order, each popped only on a wait-low edge; tx_count counts 3 → 0; no lost or duplicated bytes.
3. TX full (TX_LOG2 = 2):
   - With uart_dat_wait stuck high, write 5 bytes. Require the 5th write to see cpu_dat_wait = 1 and tx_full = 1.
   - Then release uart_dat_wait for 1 cycle. Require 1 pop, and the stalled write to complete at the following edge.
4. RX pull: UART model asserts valid with 0x5A and clears valid on uart_dat_re. Require a single one-cycle uart_dat_re pulse, rx_count = 1, cpu_dat_do = 32'h0000_005A; cpu_dat_re then returns cpu_dat_do to 32'hFFFF_FFFF.
5. RX full and stall (RX_LOG2 = 1):
   - Send 3 bytes 0x01, 0x02, 0x03 with no CPU reads. Require rx_full = 1, the 3rd byte left in the UART (no uart_dat_re), and rx_stall = 1.
   - Then read once. Require 0x01 returned and 0x03 pulled next.
   - Then assert cpu_stat_clr. Require rx_stall = 0.
6. Simultaneous RX push and CPU pop with rx_count = 3, plus a mid-stream reset:
   - Require rx_count stays 3 and the FIFO order is preserved.
   - Asserting resetn low during the TX drain empties both FIFOs next edge.

Source files
------------

// File: rtl/uart_fifo_bridge_if.sv
// CPU data-bus and UART data-register signals of the FIFO bridge.
// The bridge takes the slave view; whatever drives the CPU and UART side takes the master view.
interface uart_fifo_bridge_if;
  logic        cpu_dat_we;
  logic [31:0] cpu_dat_di;
  logic        cpu_dat_wait;
  logic        cpu_dat_re;
  logic [31:0] cpu_dat_do;
  logic [31:0] cpu_stat_do;
  logic        cpu_stat_clr;
  logic        uart_dat_we;
  logic [7:0]  uart_dat_di;
  logic        uart_dat_wait;
  logic [8:0]  uart_dat_do;
  logic        uart_dat_re;

  modport slave (
    input  cpu_dat_we, cpu_dat_di, cpu_dat_re, cpu_stat_clr, uart_dat_wait, uart_dat_do,
    output cpu_dat_wait, cpu_dat_do, cpu_stat_do, uart_dat_we, uart_dat_di, uart_dat_re
  );

  modport master (
    output cpu_dat_we, cpu_dat_di, cpu_dat_re, cpu_stat_clr, uart_dat_wait, uart_dat_do,
    input  cpu_dat_wait, cpu_dat_do, cpu_stat_do, uart_dat_we, uart_dat_di, uart_dat_re
  );
endinterface

// File: rtl/uart_fifo_bridge.sv
// TX/RX byte FIFOs between the CPU data register and the UART data register.
// TX drains into the UART write/wait handshake; RX is pulled from the UART valid/read-strobe
// interface and shown to the CPU first-word-fall-through.
module uart_fifo_bridge #(
  parameter int unsigned TX_LOG2 = 4,
  parameter int unsigned RX_LOG2 = 4
) (
  input logic               clk,
  input logic               resetn,
  uart_fifo_bridge_if.slave bus
);
  localparam int unsigned TxDepth = 2 ** TX_LOG2;
  localparam int unsigned RxDepth = 2 ** RX_LOG2;
  localparam logic [TX_LOG2:0]   TxDepthC = (TX_LOG2 + 1)'(TxDepth);
  localparam logic [RX_LOG2:0]   RxDepthC = (RX_LOG2 + 1)'(RxDepth);
  localparam logic [TX_LOG2:0]   TxCntOne = (TX_LOG2 + 1)'(1);
  localparam logic [RX_LOG2:0]   RxCntOne = (RX_LOG2 + 1)'(1);
  localparam logic [TX_LOG2-1:0] TxPtrOne = TX_LOG2'(1);
  localparam logic [RX_LOG2-1:0] RxPtrOne = RX_LOG2'(1);

  logic [7:0]         tx_mem_q [TxDepth];
  logic [TX_LOG2-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [TX_LOG2:0]   tx_cnt_q, tx_cnt_d;
  logic [7:0]         rx_mem_q [RxDepth];
  logic [RX_LOG2-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [RX_LOG2:0]   rx_cnt_q, rx_cnt_d;
  logic               uart_re_q, uart_re_d;
  logic               rx_stall_q, rx_stall_d;

  logic tx_full, tx_empty, tx_push, tx_pop;
  logic rx_full, rx_empty, rx_push, rx_pop;
  logic unused_di;

  assign unused_di = ^bus.cpu_dat_di[31:8];

  assign tx_full  = (tx_cnt_q == TxDepthC);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == RxDepthC);
  assign rx_empty = (rx_cnt_q == '0);

  // Full gating uses this cycle's flag, so a same-cycle pop never frees room for a push.
  assign tx_push = bus.cpu_dat_we & ~tx_full;
  assign tx_pop  = ~tx_empty & ~bus.uart_dat_wait;
  // The strobe guard skips the cycle in which the UART is still clearing its valid bit.
  assign rx_push = bus.uart_dat_do[8] & ~rx_full & ~uart_re_q;
  assign rx_pop  = bus.cpu_dat_re & ~rx_empty;

  assign bus.cpu_dat_wait = bus.cpu_dat_we & tx_full;
  assign bus.uart_dat_we  = ~tx_empty;
  assign bus.uart_dat_di  = tx_mem_q[tx_rptr_q];
  assign bus.uart_dat_re  = uart_re_q;
  assign bus.cpu_dat_do   = rx_empty ? 32'hFFFF_FFFF : {24'h0, rx_mem_q[rx_rptr_q]};
  assign bus.cpu_stat_do  = {11'h0, rx_stall_q, tx_full, tx_empty, rx_full, rx_empty,
                             8'(tx_cnt_q), 8'(rx_cnt_q)};

  // Next-state for pointers, counts, read strobe and the sticky stall flag.
  always_comb begin
    tx_wptr_d  = tx_push ? tx_wptr_q + TxPtrOne : tx_wptr_q;
    tx_rptr_d  = tx_pop ? tx_rptr_q + TxPtrOne : tx_rptr_q;
    rx_wptr_d  = rx_push ? rx_wptr_q + RxPtrOne : rx_wptr_q;
    rx_rptr_d  = rx_pop ? rx_rptr_q + RxPtrOne : rx_rptr_q;
    tx_cnt_d   = tx_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    if (tx_push && !tx_pop) begin
      tx_cnt_d = tx_cnt_q + TxCntOne;
    end else if (!tx_push && tx_pop) begin
      tx_cnt_d = tx_cnt_q - TxCntOne;
    end
    if (rx_push && !rx_pop) begin
      rx_cnt_d = rx_cnt_q + RxCntOne;
    end else if (!rx_push && rx_pop) begin
      rx_cnt_d = rx_cnt_q - RxCntOne;
    end
    uart_re_d  = rx_push;
    // A set in the same cycle as a clear wins.
    rx_stall_d = rx_stall_q;
    if (rx_full && bus.uart_dat_do[8]) begin
      rx_stall_d = 1'b1;
    end else if (bus.cpu_stat_clr) begin
      rx_stall_d = 1'b0;
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_cnt_q   <= '0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_cnt_q   <= '0;
      uart_re_q  <= 1'b0;
      rx_stall_q <= 1'b0;
    end else begin
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      rx_cnt_q   <= rx_cnt_d;
      uart_re_q  <= uart_re_d;
      rx_stall_q <= rx_stall_d;
    end
  end

  // FIFO storage; contents are don't-care after reset since the counts are cleared.
  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem_q[tx_wptr_q] <= bus.cpu_dat_di[7:0];
    end
    if (rx_push) begin
      rx_mem_q[rx_wptr_q] <= bus.uart_dat_do[7:0];
    end
  end
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed bench for uart_fifo_bridge: a default-depth instance (b) and a small one (s,
// TX depth 4, RX depth 2) share clock and reset.
module tb_uart_fifo_bridge;
  logic clk;
  logic resetn;
  int   tests_run;
  int   tests_failed;

  uart_fifo_bridge_if bus_b ();
  uart_fifo_bridge_if bus_s ();

  uart_fifo_bridge #(.TX_LOG2(4), .RX_LOG2(4)) u_dut_b (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_b)
  );

  uart_fifo_bridge #(.TX_LOG2(2), .RX_LOG2(1)) u_dut_s (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    cyc();
    cyc();
    tests_run++;
    if (bus_b.uart_dat_we !== 1'b0) begin
      tests_failed++; $display("FAIL reset_uart_we: got %0h expected 0", bus_b.uart_dat_we);
    end
    tests_run++;
    if (bus_b.uart_dat_re !== 1'b0) begin
      tests_failed++; $display("FAIL reset_uart_re: got %0h expected 0", bus_b.uart_dat_re);
    end
    tests_run++;
    if (bus_b.cpu_dat_do !== 32'hFFFF_FFFF) begin
      tests_failed++; $display("FAIL reset_cpu_do: got %h expected ffffffff", bus_b.cpu_dat_do);
    end
    tests_run++;
    if (bus_b.cpu_stat_do !== 32'h0005_0000) begin
      tests_failed++; $display("FAIL reset_stat_b: got %h expected 00050000", bus_b.cpu_stat_do);
    end
    tests_run++;
    if (bus_s.cpu_stat_do !== 32'h0005_0000) begin
      tests_failed++; $display("FAIL reset_stat_s: got %h expected 00050000", bus_s.cpu_stat_do);
    end
    resetn = 1'b1;
    cyc();
  endtask

  task automatic test_tx_order();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
    bus_b.uart_dat_wait = 1'b1;
    bus_b.cpu_dat_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_b.cpu_dat_di = {24'hABCDEF, exp_b[i]};
      cyc();
    end
    bus_b.cpu_dat_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      repeat (10) cyc();
      tests_run++;
      if (bus_b.uart_dat_di !== exp_b[i] || bus_b.uart_dat_we !== 1'b1) begin
        tests_failed++;
        $display("FAIL tx_order_head%0d: got we=%0h di=%h expected we=1 di=%h",
                 i, bus_b.uart_dat_we, bus_b.uart_dat_di, exp_b[i]);
      end
      tests_run++;
      if (bus_b.cpu_stat_do[15:8] !== 8'(3 - i)) begin
        tests_failed++;
        $display("FAIL tx_order_hold%0d: got count %0d expected %0d",
                 i, bus_b.cpu_stat_do[15:8], 3 - i);
      end
      bus_b.uart_dat_wait = 1'b0;
      cyc();
      bus_b.uart_dat_wait = 1'b1;
      tests_run++;
      if (bus_b.cpu_stat_do[15:8] !== 8'(2 - i)) begin
        tests_failed++;
        $display("FAIL tx_order_pop%0d: got count %0d expected %0d",
                 i, bus_b.cpu_stat_do[15:8], 2 - i);
      end
    end
    tests_run++;
    if (bus_b.uart_dat_we !== 1'b0 || bus_b.cpu_stat_do[18] !== 1'b1) begin
      tests_failed++;
      $display("FAIL tx_order_empty: got we=%0h tx_empty=%0h expected we=0 tx_empty=1",
               bus_b.uart_dat_we, bus_b.cpu_stat_do[18]);
    end
  endtask

  task automatic test_tx_full();
    bus_s.uart_dat_wait = 1'b1;
    bus_s.cpu_dat_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_s.cpu_dat_di = 32'h10 + 32'(i);
      cyc();
    end
    bus_s.cpu_dat_di = 32'h14;
    #1;
    tests_run++;
    if (bus_s.cpu_dat_wait !== 1'b1 || bus_s.cpu_stat_do[19] !== 1'b1) begin
      tests_failed++;
      $display("FAIL tx_full_stall: got wait=%0h full=%0h expected wait=1 full=1",
               bus_s.cpu_dat_wait, bus_s.cpu_stat_do[19]);
    end
    cyc();
    tests_run++;
    if (bus_s.cpu_stat_do[15:8] !== 8'd4) begin
      tests_failed++; $display("FAIL tx_full_blocked: got count %0d expected 4",
                               bus_s.cpu_stat_do[15:8]);
    end
    bus_s.uart_dat_wait = 1'b0;
    #1;
    tests_run++;
    if (bus_s.cpu_dat_wait !== 1'b1) begin
      tests_failed++; $display("FAIL tx_full_wait_on_pop: got %0h expected 1",
                               bus_s.cpu_dat_wait);
    end
    cyc();
    bus_s.uart_dat_wait = 1'b1;
    #1;
    tests_run++;
    if (bus_s.cpu_stat_do[15:8] !== 8'd3 || bus_s.cpu_dat_wait !== 1'b0 ||
        bus_s.uart_dat_di !== 8'h11) begin
      tests_failed++;
      $display("FAIL tx_full_one_pop: got count=%0d wait=%0h di=%h expected 3 0 11",
               bus_s.cpu_stat_do[15:8], bus_s.cpu_dat_wait, bus_s.uart_dat_di);
    end
    cyc();
    bus_s.cpu_dat_we = 1'b0;
    tests_run++;
    if (bus_s.cpu_stat_do[15:8] !== 8'd4) begin
      tests_failed++; $display("FAIL tx_full_retry: got count %0d expected 4",
                               bus_s.cpu_stat_do[15:8]);
    end
    bus_s.uart_dat_wait = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (bus_s.uart_dat_di !== 8'(8'h11 + i)) begin
        tests_failed++; $display("FAIL tx_full_drain%0d: got %h expected %h",
                                 i, bus_s.uart_dat_di, 8'(8'h11 + i));
      end
      cyc();
    end
    bus_s.uart_dat_wait = 1'b1;
    tests_run++;
    if (bus_s.cpu_stat_do[15:8] !== 8'd0 || bus_s.uart_dat_we !== 1'b0) begin
      tests_failed++; $display("FAIL tx_full_drained: got count=%0d we=%0h expected 0 0",
                               bus_s.cpu_stat_do[15:8], bus_s.uart_dat_we);
    end
  endtask

  task automatic test_rx_pull();
    bus_b.uart_dat_do = 9'h15A;
    cyc();
    tests_run++;
    if (bus_b.uart_dat_re !== 1'b1 || bus_b.cpu_dat_do !== 32'h0000_005A) begin
      tests_failed++; $display("FAIL rx_pull_first: got re=%0h do=%h expected re=1 do=0000005a",
                               bus_b.uart_dat_re, bus_b.cpu_dat_do);
    end
    cyc();
    // UART saw the strobe at this edge and drops valid.
    bus_b.uart_dat_do = 9'h000;
    tests_run++;
    if (bus_b.uart_dat_re !== 1'b0) begin
      tests_failed++; $display("FAIL rx_pull_pulse: got re=%0h expected 0", bus_b.uart_dat_re);
    end
    cyc();
    cyc();
    tests_run++;
    if (bus_b.cpu_stat_do[7:0] !== 8'd1 || bus_b.cpu_dat_do !== 32'h0000_005A) begin
      tests_failed++; $display("FAIL rx_pull_count: got count=%0d do=%h expected 1 0000005a",
                               bus_b.cpu_stat_do[7:0], bus_b.cpu_dat_do);
    end
    bus_b.cpu_dat_re = 1'b1;
    cyc();
    bus_b.cpu_dat_re = 1'b0;
    tests_run++;
    if (bus_b.cpu_dat_do !== 32'hFFFF_FFFF || bus_b.cpu_stat_do[7:0] !== 8'd0) begin
      tests_failed++; $display("FAIL rx_pull_read: got do=%h count=%0d expected ffffffff 0",
                               bus_b.cpu_dat_do, bus_b.cpu_stat_do[7:0]);
    end
  endtask

  task automatic test_rx_stall();
    for (int i = 1; i <= 3; i++) begin
      bus_s.uart_dat_do = {1'b1, 8'(i)};
      cyc();
      cyc();
    end
    cyc();
    tests_run++;
    if (bus_s.uart_dat_re !== 1'b0 || bus_s.cpu_stat_do[17] !== 1'b1 ||
        bus_s.cpu_stat_do[20] !== 1'b1 || bus_s.cpu_stat_do[7:0] !== 8'd2) begin
      tests_failed++;
      $display("FAIL rx_stall_full: got re=%0h full=%0h stall=%0h count=%0d expected 0 1 1 2",
               bus_s.uart_dat_re, bus_s.cpu_stat_do[17], bus_s.cpu_stat_do[20],
               bus_s.cpu_stat_do[7:0]);
    end
    tests_run++;
    if (bus_s.cpu_dat_do !== 32'h0000_0001) begin
      tests_failed++; $display("FAIL rx_stall_head: got %h expected 00000001", bus_s.cpu_dat_do);
    end
    bus_s.cpu_dat_re = 1'b1;
    cyc();
    bus_s.cpu_dat_re = 1'b0;
    tests_run++;
    if (bus_s.uart_dat_re !== 1'b0 || bus_s.cpu_stat_do[7:0] !== 8'd1) begin
      tests_failed++; $display("FAIL rx_stall_pop: got re=%0h count=%0d expected 0 1",
                               bus_s.uart_dat_re, bus_s.cpu_stat_do[7:0]);
    end
    cyc();
    tests_run++;
    if (bus_s.uart_dat_re !== 1'b1 || bus_s.cpu_stat_do[7:0] !== 8'd2) begin
      tests_failed++; $display("FAIL rx_stall_pull3: got re=%0h count=%0d expected 1 2",
                               bus_s.uart_dat_re, bus_s.cpu_stat_do[7:0]);
    end
    cyc();
    bus_s.uart_dat_do = 9'h000;
    for (int i = 2; i <= 3; i++) begin
      tests_run++;
      if (bus_s.cpu_dat_do !== 32'(i)) begin
        tests_failed++; $display("FAIL rx_stall_order%0d: got %h expected %h",
                                 i, bus_s.cpu_dat_do, 32'(i));
      end
      bus_s.cpu_dat_re = 1'b1;
      cyc();
      bus_s.cpu_dat_re = 1'b0;
    end
    tests_run++;
    if (bus_s.cpu_dat_do !== 32'hFFFF_FFFF || bus_s.cpu_stat_do[20] !== 1'b1) begin
      tests_failed++; $display("FAIL rx_stall_sticky: got do=%h stall=%0h expected ffffffff 1",
                               bus_s.cpu_dat_do, bus_s.cpu_stat_do[20]);
    end
    bus_s.cpu_stat_clr = 1'b1;
    cyc();
    bus_s.cpu_stat_clr = 1'b0;
    tests_run++;
    if (bus_s.cpu_stat_do[20] !== 1'b0) begin
      tests_failed++; $display("FAIL rx_stall_clr: got %0h expected 0", bus_s.cpu_stat_do[20]);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      bus_b.uart_dat_do = {1'b1, 8'(8'hA0 + i)};
      cyc();
      cyc();
    end
    tests_run++;
    if (bus_b.cpu_stat_do[7:0] !== 8'd3) begin
      tests_failed++; $display("FAIL b2b_fill: got count %0d expected 3", bus_b.cpu_stat_do[7:0]);
    end
    bus_b.uart_dat_do = 9'h1A4;
    bus_b.cpu_dat_re = 1'b1;
    cyc();
    bus_b.cpu_dat_re = 1'b0;
    tests_run++;
    if (bus_b.cpu_stat_do[7:0] !== 8'd3 || bus_b.uart_dat_re !== 1'b1 ||
        bus_b.cpu_dat_do !== 32'h0000_00A2) begin
      tests_failed++;
      $display("FAIL b2b_push_pop: got count=%0d re=%0h do=%h expected 3 1 000000a2",
               bus_b.cpu_stat_do[7:0], bus_b.uart_dat_re, bus_b.cpu_dat_do);
    end
    cyc();
    bus_b.uart_dat_do = 9'h000;
    for (int i = 2; i <= 4; i++) begin
      tests_run++;
      if (bus_b.cpu_dat_do !== 32'(8'hA0 + i)) begin
        tests_failed++; $display("FAIL b2b_order%0d: got %h expected %h",
                                 i, bus_b.cpu_dat_do, 32'(8'hA0 + i));
      end
      bus_b.cpu_dat_re = 1'b1;
      cyc();
      bus_b.cpu_dat_re = 1'b0;
    end
    tests_run++;
    if (bus_b.cpu_stat_do !== 32'h0005_0000) begin
      tests_failed++; $display("FAIL b2b_empty: got %h expected 00050000", bus_b.cpu_stat_do);
    end
  endtask

  task automatic test_mid_reset();
    bus_b.uart_dat_do = 9'h177;
    cyc();
    bus_b.uart_dat_do = 9'h000;
    bus_b.uart_dat_wait = 1'b1;
    bus_b.cpu_dat_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_b.cpu_dat_di = 32'h60 + 32'(i);
      cyc();
    end
    bus_b.cpu_dat_we = 1'b0;
    bus_b.uart_dat_wait = 1'b0;
    cyc();
    tests_run++;
    if (bus_b.cpu_stat_do[15:0] !== 16'h0201 || bus_b.uart_dat_di !== 8'h61) begin
      tests_failed++; $display("FAIL mid_reset_pre: got stat=%h di=%h expected ....0201 61",
                               bus_b.cpu_stat_do, bus_b.uart_dat_di);
    end
    resetn = 1'b0;
    cyc();
    tests_run++;
    if (bus_b.cpu_stat_do !== 32'h0005_0000 || bus_b.uart_dat_we !== 1'b0 ||
        bus_b.cpu_dat_do !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL mid_reset: got stat=%h we=%0h do=%h expected 00050000 0 ffffffff",
               bus_b.cpu_stat_do, bus_b.uart_dat_we, bus_b.cpu_dat_do);
    end
    resetn = 1'b1;
    bus_b.uart_dat_wait = 1'b1;
    cyc();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    resetn = 1'b0;
    bus_b.cpu_dat_we = 1'b0; bus_b.cpu_dat_di = '0; bus_b.cpu_dat_re = 1'b0;
    bus_b.cpu_stat_clr = 1'b0; bus_b.uart_dat_wait = 1'b0; bus_b.uart_dat_do = '0;
    bus_s.cpu_dat_we = 1'b0; bus_s.cpu_dat_di = '0; bus_s.cpu_dat_re = 1'b0;
    bus_s.cpu_stat_clr = 1'b0; bus_s.uart_dat_wait = 1'b0; bus_s.uart_dat_do = '0;
    test_reset();
    test_tx_order();
    test_tx_full();
    test_rx_pull();
    test_rx_stall();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
